// File: rtl/cp0_pkg.sv
// Shared definitions for coprocessor 0: register numbers, bit positions
// and exception codes used by cp0_ctrl and cp0_timer.
package cp0_pkg;

  // CP0 register numbers as they appear in the rd field of mtc0/mfc0
  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_SR      = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;
  localparam logic [4:0] CP0_REG_PRID    = 5'd15;

  // Bit positions inside SR and Cause
  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;
  localparam int IRQ_BASE      = 10;
  localparam int CAUSE_TI_BIT  = 30;
  localparam int CAUSE_BD_BIT  = 31;

  // Exception codes reported in Cause.ExcCode
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0. Only instantiated when CP0_TIMER_EN is defined.
// Count free-runs and wraps; Count==Compare latches a pending flag that only
// a Compare write clears.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        flag_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        flag_q, flag_d;

  // Next-state: software writes beat the increment, and a Compare write beats a new match
  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    flag_d    = flag_q | (count_q == compare_q);
    if (count_we_i) begin
      count_d = wdata_i;
    end
    if (compare_we_i) begin
      compare_d = wdata_i;
      flag_d    = 1'b0;
    end
  end

  // Timer state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      flag_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      flag_q    <= flag_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign flag_o    = flag_q;

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor 0 beside the M stage: SR/Cause/EPC/PRId, interrupt vs exception
// arbitration, flush request, EPC bypass for eret and mfc0 read mux.
// Optional Count/Compare timer is compiled in with the CP0_TIMER_EN macro.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_HWINT  = 6,
  parameter logic [31:0] PRID_VAL   = 32'h0000_0000,
  parameter int unsigned TIMER_LINE = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bd_in,
  input  logic [4:0]           exc_code_in,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic [31:0]          pc_m,
  input  logic                 we,
  input  logic                 eret,
  input  logic [4:0]           addr,
  input  logic [31:0]          wdata,
  output logic                 req,
  output logic                 exl,
  output logic [31:0]          epc_out,
  output logic [31:0]          rdata
);

  logic [NUM_HWINT-1:0] im_q, im_d;
  logic                 exl_q, exl_d;
  logic                 ie_q, ie_d;
  logic [31:0]          epc_q, epc_d;
  logic [4:0]           exccode_q, exccode_d;
  logic                 bd_q, bd_d;
  logic [NUM_HWINT-1:0] ip_q;

  logic                 timer_flag;
  logic [NUM_HWINT-1:0] timer_vec;
  logic [NUM_HWINT-1:0] irq_vec;
  logic                 int_req;
  logic                 exc_req;
  logic [31:0]          pc_adj;
  logic [31:0]          epc_next;
  logic                 wr_en;
  logic [31:0]          sr_val;
  logic [31:0]          cause_val;

  // Software writes only land when no exception is taken and no eret is in M
  assign wr_en = we & ~req & ~eret;

`ifdef CP0_TIMER_EN
  logic [31:0] count_val;
  logic [31:0] compare_val;

  cp0_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .count_we_i   (wr_en && (addr == CP0_REG_COUNT)),
    .compare_we_i (wr_en && (addr == CP0_REG_COMPARE)),
    .wdata_i      (wdata),
    .count_o      (count_val),
    .compare_o    (compare_val),
    .flag_o       (timer_flag)
  );
`else
  assign timer_flag = 1'b0;
`endif

  assign timer_vec = NUM_HWINT'(timer_flag) << TIMER_LINE;
  assign irq_vec   = hw_int | timer_vec;

  assign int_req = (|(irq_vec & im_q)) & ~exl_q & ie_q;
  assign exc_req = (exc_code_in != 5'd0) & ~exl_q;
  assign req     = int_req | exc_req;

  assign pc_adj   = bd_in ? (pc_m - 32'd4) : pc_m;
  assign epc_next = {pc_adj[31:2], 2'b00};
  assign epc_out  = req ? epc_next : epc_q;
  assign exl      = exl_q;

  // Register next-state with req > eret > mtc0 precedence
  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    epc_d     = epc_q;
    exccode_d = exccode_q;
    bd_d      = bd_q;
    if (req) begin
      exccode_d = int_req ? EXC_INT : exc_code_in;
      exl_d     = 1'b1;
      epc_d     = epc_next;
      bd_d      = bd_in;
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (we) begin
      case (addr)
        CP0_REG_SR: begin
          im_d  = wdata[IRQ_BASE +: NUM_HWINT];
          exl_d = wdata[SR_EXL_BIT];
          ie_d  = wdata[SR_IE_BIT];
        end
        CP0_REG_EPC: epc_d = wdata;
        default: ;
      endcase
    end
  end

  // CP0 state registers; Cause.IP tracks the request lines every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      epc_q     <= '0;
      exccode_q <= '0;
      bd_q      <= 1'b0;
      ip_q      <= '0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      epc_q     <= epc_d;
      exccode_q <= exccode_d;
      bd_q      <= bd_d;
      ip_q      <= irq_vec;
    end
  end

  // Assemble the architectural SR and Cause words; unimplemented bits read 0
  always_comb begin
    sr_val                          = '0;
    sr_val[IRQ_BASE +: NUM_HWINT]   = im_q;
    sr_val[SR_EXL_BIT]              = exl_q;
    sr_val[SR_IE_BIT]               = ie_q;
    cause_val                       = '0;
    cause_val[CAUSE_BD_BIT]         = bd_q;
    cause_val[CAUSE_TI_BIT]         = timer_flag;
    cause_val[IRQ_BASE +: NUM_HWINT] = ip_q;
    cause_val[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exccode_q;
  end

  // mfc0 read mux; EPC reads the stored register, not the bypass
  always_comb begin
    rdata = '0;
    case (addr)
      CP0_REG_SR:      rdata = sr_val;
      CP0_REG_CAUSE:   rdata = cause_val;
      CP0_REG_EPC:     rdata = epc_q;
      CP0_REG_PRID:    rdata = PRID_VAL;
`ifdef CP0_TIMER_EN
      CP0_REG_COUNT:   rdata = count_val;
      CP0_REG_COMPARE: rdata = compare_val;
`endif
      default:         rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl (default parameters). Directed scenarios
// plus randomized traffic compared against a behavioural CP0 model.
// Timer scenarios are included when CP0_TIMER_EN is defined.
module tb_cp0_ctrl;

  localparam int NHW = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic           bd_in;
  logic [4:0]     exc_code_in;
  logic [NHW-1:0] hw_int;
  logic [31:0]    pc_m;
  logic           we;
  logic           eret;
  logic [4:0]     addr;
  logic [31:0]    wdata;
  logic           req;
  logic           exl;
  logic [31:0]    epc_out;
  logic [31:0]    rdata;

  int checks = 0;
  int errors = 0;

  // Behavioural model state, kept as plain architectural fields
  logic [NHW-1:0] mIm, mIp;
  logic           mExl, mIe, mBd, mFlag;
  logic [4:0]     mExc;
  logic [31:0]    mEpc, mCount, mCompare;

  cp0_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .bd_in       (bd_in),
    .exc_code_in (exc_code_in),
    .hw_int      (hw_int),
    .pc_m        (pc_m),
    .we          (we),
    .eret        (eret),
    .addr        (addr),
    .wdata       (wdata),
    .req         (req),
    .exl         (exl),
    .epc_out     (epc_out),
    .rdata       (rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic logic [NHW-1:0] timerLine();
`ifdef CP0_TIMER_EN
    return mFlag ? NHW'(32) : '0;
`else
    return '0;
`endif
  endfunction

  function automatic logic modelInt();
    return (((hw_int | timerLine()) & mIm) != 0) && !mExl && mIe;
  endfunction

  function automatic logic modelReq();
    return modelInt() || ((exc_code_in != 0) && !mExl);
  endfunction

  function automatic logic [31:0] modelEpcNext();
    logic [31:0] p;
    p = bd_in ? pc_m - 32'd4 : pc_m;
    return (p / 4) * 4;
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    case (a)
      5'd12: return (32'(mIm) << 10) + (32'(mExl) << 1) + 32'(mIe);
      5'd13: return (32'(mBd) << 31) + (32'(mFlag) << 30) + (32'(mIp) << 10) + (32'(mExc) << 2);
      5'd14: return mEpc;
      5'd15: return 32'h0000_0000;
`ifdef CP0_TIMER_EN
      5'd9:  return mCount;
      5'd11: return mCompare;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelReset();
    mIm = '0; mIp = '0; mExl = 0; mIe = 0; mBd = 0; mFlag = 0;
    mExc = '0; mEpc = '0; mCount = '0; mCompare = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic modelStep();
    logic [NHW-1:0] irq;
    logic take, intr;
`ifdef CP0_TIMER_EN
    logic hit, cntWr, cmpWr;
`endif
    irq  = hw_int | timerLine();
    intr = modelInt();
    take = modelReq();
`ifdef CP0_TIMER_EN
    hit   = (mCount == mCompare);
    cntWr = we && !take && !eret && addr == 5'd9;
    cmpWr = we && !take && !eret && addr == 5'd11;
`endif
    if (take) begin
      mExc = intr ? 5'd0 : exc_code_in;
      mExl = 1;
      mEpc = modelEpcNext();
      mBd  = bd_in;
    end else if (eret) begin
      mExl = 0;
    end else if (we) begin
      if (addr == 5'd12) begin
        mIm  = wdata[15:10];
        mExl = wdata[1];
        mIe  = wdata[0];
      end else if (addr == 5'd14) begin
        mEpc = wdata;
      end
    end
    mIp = irq;
`ifdef CP0_TIMER_EN
    if (cmpWr) mFlag = 0;
    else if (hit) mFlag = 1;
    mCount = cntWr ? wdata : mCount + 32'd1;
    if (cmpWr) mCompare = wdata;
`endif
  endtask

  // Apply one cycle of inputs (entered at a negedge), check, clock, update model
  task automatic applyStimulus(input logic b, input logic [4:0] ec, input logic [NHW-1:0] hw,
                               input logic [31:0] pc, input logic w, input logic er,
                               input logic [4:0] a, input logic [31:0] wd,
                               output logic oReq, output logic oExl,
                               output logic [31:0] oEpc, output logic [31:0] oRd);
    bd_in = b; exc_code_in = ec; hw_int = hw; pc_m = pc;
    we = w; eret = er; addr = a; wdata = wd;
    #1;
    oReq = req; oExl = exl; oEpc = epc_out; oRd = rdata;
    checkOutput("model_req", {31'b0, req}, {31'b0, modelReq()});
    checkOutput("model_exl", {31'b0, exl}, {31'b0, mExl});
    checkOutput("model_epc_out", epc_out, modelReq() ? modelEpcNext() : mEpc);
    checkOutput("model_rdata", rdata, modelRead(a));
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  logic        oReq, oExl;
  logic [31:0] oEpc, oRd;

  task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
    applyStimulus(0, 0, 0, 32'h0, 1, 0, a, d, oReq, oExl, oEpc, oRd);
  endtask

  task automatic idle(input logic [4:0] a);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, a, 32'h0, oReq, oExl, oEpc, oRd);
  endtask

  task automatic doEret();
    applyStimulus(0, 0, 0, 32'h0, 0, 1, 5'd0, 32'h0, oReq, oExl, oEpc, oRd);
  endtask

  logic [4:0] addrTable [8];

  initial begin
    addrTable = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd3};
    reset = 1; bd_in = 0; exc_code_in = 0; hw_int = 0; pc_m = 0;
    we = 0; eret = 0; addr = 0; wdata = 0;
    repeat (3) @(posedge clk);
    modelReset();
    @(negedge clk);
    reset = 0;

    // Reset state
    idle(5'd13);
    checkOutput("rst_req", {31'b0, oReq}, 32'd0);
    checkOutput("rst_exl", {31'b0, oExl}, 32'd0);
    checkOutput("rst_epc_out", oEpc, 32'd0);
    checkOutput("rst_cause", oRd, 32'd0);
    idle(5'd12);
    checkOutput("rst_sr", oRd, 32'd0);
    idle(5'd14);
    checkOutput("rst_epc", oRd, 32'd0);

`ifdef CP0_TIMER_EN
    writeReg(5'd11, 32'hFFFF_FFF0);
`endif

    // Interrupt on hw_int[2] with all IM set
    writeReg(5'd12, 32'h0000_FC01);
    applyStimulus(0, 0, 6'b000100, 32'h3010, 0, 0, 5'd0, 0, oReq, oExl, oEpc, oRd);
    checkOutput("int_req", {31'b0, oReq}, 32'd1);
    checkOutput("int_epc_bypass", oEpc, 32'h3010);
    idle(5'd13);
    checkOutput("int_cause", oRd, 32'h0000_1000);
    checkOutput("int_exl", {31'b0, oExl}, 32'd1);
    checkOutput("int_req_after", {31'b0, oReq}, 32'd0);
    doEret();
    writeReg(5'd12, 32'h0);

    // Overflow in a delay slot
    applyStimulus(1, 5'd12, 0, 32'h3008, 0, 0, 5'd0, 0, oReq, oExl, oEpc, oRd);
    checkOutput("ov_req", {31'b0, oReq}, 32'd1);
    checkOutput("ov_epc_bypass", oEpc, 32'h3004);
    idle(5'd14);
    checkOutput("ov_epc", oRd, 32'h3004);
    idle(5'd13);
    checkOutput("ov_cause", oRd, 32'h8000_0030);
    doEret();

    // EXL masks everything until eret
    writeReg(5'd12, 32'h0000_FC03);
    applyStimulus(0, 5'd10, 6'b000001, 32'h5000, 0, 0, 5'd0, 0, oReq, oExl, oEpc, oRd);
    checkOutput("exl_mask_req", {31'b0, oReq}, 32'd0);
    applyStimulus(0, 0, 6'b000001, 32'h5004, 0, 1, 5'd0, 0, oReq, oExl, oEpc, oRd);
    checkOutput("eret_cycle_req", {31'b0, oReq}, 32'd0);
    applyStimulus(0, 0, 6'b000001, 32'h5008, 0, 0, 5'd0, 0, oReq, oExl, oEpc, oRd);
    checkOutput("post_eret_req", {31'b0, oReq}, 32'd1);
    doEret();
    writeReg(5'd12, 32'h0);

    // mtc0 SR dropped under a simultaneous exception
    applyStimulus(0, 5'd4, 0, 32'h6000, 1, 0, 5'd12, 32'hFFFF_FFFF, oReq, oExl, oEpc, oRd);
    checkOutput("drop_req", {31'b0, oReq}, 32'd1);
    idle(5'd12);
    checkOutput("drop_sr", oRd, 32'h0000_0002);
    idle(5'd13);
    checkOutput("drop_cause", oRd, 32'h0000_0010);
    doEret();
    writeReg(5'd12, 32'h0);

    // Interrupt outranks a simultaneous exception
    writeReg(5'd12, 32'h0000_FC01);
    applyStimulus(0, 5'd5, 6'b000001, 32'h4000, 0, 0, 5'd0, 0, oReq, oExl, oEpc, oRd);
    checkOutput("both_req", {31'b0, oReq}, 32'd1);
    idle(5'd13);
    checkOutput("both_cause", oRd, 32'h0000_0400);
    idle(5'd14);
    checkOutput("both_epc", oRd, 32'h4000);
    doEret();
    writeReg(5'd12, 32'h0);

`ifdef CP0_TIMER_EN
    begin
      logic seen;
      logic [31:0] cntAtReq;
      seen = 0;
      cntAtReq = 0;
      writeReg(5'd11, 32'd20);
      writeReg(5'd9, 32'd15);
      writeReg(5'd12, 32'h0000_8001);
      for (int i = 0; i < 30 && !seen; i++) begin
        idle(5'd9);
        if (oReq) begin
          seen = 1;
          cntAtReq = oRd;
        end
      end
      checkOutput("timer_req_seen", {31'b0, seen}, 32'd1);
      checkOutput("timer_count_at_req", cntAtReq, 32'd21);
      writeReg(5'd11, 32'hFFFF_0000);
      idle(5'd13);
      checkOutput("timer_ti_cleared", {31'b0, oRd[30]}, 32'd0);
      doEret();
      writeReg(5'd12, 32'h0);
    end
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] ec;
      logic [NHW-1:0] hw;
      logic [4:0] a;
      case ($urandom_range(0, 7))
        0: ec = 5'd4;
        1: ec = 5'd12;
        2: ec = 5'd10;
        default: ec = 5'd0;
      endcase
      hw = ($urandom_range(0, 3) == 0) ? NHW'($urandom) : '0;
      a  = addrTable[$urandom_range(0, 7)];
      applyStimulus(1'($urandom), ec, hw, $urandom, ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 7) == 0), a, $urandom, oReq, oExl, oEpc, oRd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
